req_encoder8_256: RTL

Sequential 256-to-8 index encoder that works in the opposite direction to the FIFO's 8-to-256 one-hot select decoder. It captures a 256-bit request/occupancy vector and emits the index of every set bit, lowest index first, one index per accepted handshake. It sits on the read side of the FIFO storage array. It converts a flag vector back into 8-bit addresses for the read mux and for status logic.

---
 rtl/req_encoder8_256_pkg.sv | 17 +
 rtl/req_encoder8_256_prio.sv | 53 +++++
 rtl/req_encoder8_256.sv | 95 +++++++++
 3 files changed

// File: rtl/req_encoder8_256_pkg.sv
// Shared definitions for the 256-to-8 sequential request encoder.
//   NREQ     : number of request bits
//   IDX_W    : index width
//   SERVED_W : width of the served counter (must reach 256)
//   state_t  : FSM state encoding
package req_encoder8_256_pkg;

  localparam int NREQ     = 256;
  localparam int IDX_W    = 8;
  localparam int SERVED_W = 9;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/req_encoder8_256_prio.sv
// Combinational lowest-index-first priority encoders.
//   prio_encoder7_128 : req[127:0] -> index[6:0], any
//   prio_encoder8_256 : req[255:0] -> index[7:0], any[0:0]
// The 256-bit encoder is two 128-bit halves; the lower half has priority.
// When nothing is set, index is don't-care (the caller masks it with any).

module prio_encoder7_128 (
  input  logic [127:0] req,
  output logic [6:0]   index,
  output logic         any
);

  always_comb begin
    index = '0;
    any   = |req;
    // Scan downward so the lowest set bit is the last assignment.
    for (int i = 127; i >= 0; i--) begin
      if (req[i]) index = 7'(i);
    end
  end

endmodule

module prio_encoder8_256
  import req_encoder8_256_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  output logic [IDX_W-1:0] index,
  output logic [0:0]       any
);

  logic [6:0] lo_index;
  logic [6:0] hi_index;
  logic       lo_any;
  logic       hi_any;

  prio_encoder7_128 u_lo (
    .req   (req[127:0]),
    .index (lo_index),
    .any   (lo_any)
  );

  prio_encoder7_128 u_hi (
    .req   (req[255:128]),
    .index (hi_index),
    .any   (hi_any)
  );

  // Index bit 7 is simply "lower half empty".
  assign index = lo_any ? {1'b0, lo_index} : {1'b1, hi_index};
  assign any   = lo_any | hi_any;

endmodule

// File: rtl/req_encoder8_256.sv
// Sequential 256-to-8 index encoder: captures a request vector and emits
// the index of every set bit, lowest first, one per valid/ready handshake.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture req_in (only while idle)
//   req_in    : request vector
//   ready     : consumer accepts data_out
//   valid     : data_out holds a pending index
//   data_out  : lowest set index of the pending vector, 0 when none
//   busy      : vector being served, load ignored
//   done      : one-cycle pulse after the vector has been fully served
//   served    : indices emitted since the last load
//
// state | meaning
// IDLE  | no vector pending, load accepted
// SERVE | pending vector non-empty, one index offered per cycle

module req_encoder8_256
  import req_encoder8_256_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [NREQ-1:0]     req_in,
  input  logic                ready,
  output logic                valid,
  output logic [IDX_W-1:0]    data_out,
  output logic                busy,
  output logic                done,
  output logic [SERVED_W-1:0] served
);

  state_t              state, state_n;
  logic [NREQ-1:0]     pending, pending_n;
  logic [NREQ-1:0]     pending_clr;
  logic [SERVED_W-1:0] served_n;
  logic                done_n;
  logic [IDX_W-1:0]    enc_index;
  logic [0:0]          enc_any;

  prio_encoder8_256 u_prio (
    .req   (pending),
    .index (enc_index),
    .any   (enc_any)
  );

  assign data_out    = enc_any[0] ? enc_index : '0;
  assign pending_clr = pending & ~({{(NREQ-1){1'b0}}, 1'b1} << data_out);

  // valid and busy come straight from the state flop.
  assign valid = (state == SERVE);
  assign busy  = (state == SERVE);

  always_comb begin
    state_n   = state;
    pending_n = pending;
    served_n  = served;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          pending_n = req_in;
          served_n  = '0;
          if (req_in == '0) done_n  = 1'b1;
          else              state_n = SERVE;
        end
      end
      SERVE: begin
        if (ready) begin
          pending_n = pending_clr;
          served_n  = served + SERVED_W'(1);
          if (pending_clr == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      served  <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      served  <= served_n;
      done    <= done_n;
    end
  end

endmodule
